// File: rtl/risc_prog_server.sv
// risc_prog_server: host-side program memory, fetch server, run/halt sequencer and result FIFO for the RISC core.
module risc_prog_server #(
   parameter int          PROG_DEPTH = 256,
   parameter int          RES_DEPTH  = 8,
   parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
   parameter logic [15:0] MAX_INSTR  = 16'hFFFF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load_we,
   input  logic [7:0]                   load_addr,
   input  logic [31:0]                  load_data,
   input  logic                         start,
   output logic                         core_rst,
   output logic [31:0]                  instrn,
   input  logic                         rd_instr,
   input  logic [10:0]                  psw,
   input  logic                         endofinstrn,
   input  logic [63:0]                  result_data,
   input  logic                         out_valid,
   input  logic                         stack_full,
   input  logic                         res_rd,
   output logic [63:0]                  res_data,
   output logic                         res_empty,
   output logic [$clog2(RES_DEPTH):0]   res_count,
   output logic                         res_ovf,
   output logic                         busy,
   output logic                         done,
   output logic [1:0]                   halt_cause,
   output logic [15:0]                  instr_count
);
   localparam int AW = $clog2(RES_DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [31:0] mem [PROG_DEPTH];
   logic [63:0] fifo [RES_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic enter, halt, push, pop, full, wr_en;
   logic [1:0] cause;
   logic unused_flags;
   assign unused_flags = ^psw[2:0];
   always_comb begin
      enter = start && state != RUN;
      cause = (rd_instr && instrn == HALT_WORD) ? 2'b01 :
              stack_full ? 2'b10 :
              (endofinstrn && instr_count == MAX_INSTR - 16'd1) ? 2'b11 : 2'b00;
      halt  = state == RUN && cause != 2'b00;
      push  = busy && out_valid;
      pop   = res_rd && !res_empty;
      full  = res_count == (AW+1)'(RES_DEPTH);
      wr_en = push && (!full || pop);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   always_comb begin
      state_nxt = enter ? RUN : halt ? DONE : state;
   end
   always_comb begin
      busy     = state == RUN;
      done     = state == DONE;
      core_rst = state != RUN;
   end
   always_ff @(posedge clk)
      if (load_we && !busy) mem[load_addr] <= load_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) instrn <= '0;
      else       instrn <= busy ? mem[psw[10:3]] : '0;
   // Run bookkeeping: cleared on entry, frozen once the run halts
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         instr_count <= '0;
         halt_cause  <= '0;
      end else if (enter) begin
         instr_count <= '0;
         halt_cause  <= '0;
      end else begin
         if (busy && endofinstrn && instr_count != MAX_INSTR) instr_count <= instr_count + 16'd1;
         if (halt) halt_cause <= cause;
      end
   always_ff @(posedge clk)
      if (wr_en) fifo[wr_ptr] <= result_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         res_count <= '0;
         res_ovf   <= 1'b0;
      end else if (enter) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         res_count <= '0;
         res_ovf   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         res_count <= res_count + (AW+1)'(wr_en) - (AW+1)'(pop);
         if (push && full && !pop) res_ovf <= 1'b1;
      end
   assign res_data  = fifo[rd_ptr];
   assign res_empty = res_count == '0;
endmodule

// File: tb/tb_risc_prog_server.sv
// tb_risc_prog_server: directed stimulus against a queue-based reference model of the program server.
module tb_risc_prog_server;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] WA = 32'h1111_0001, WB = 32'h2222_0002, WC = 32'h3333_0003;
   localparam int MAXI = 5;
   logic clk = 1'b0, reset = 1'b1;
   logic load_we = 0, start = 0, rd_instr = 0, endofinstrn = 0, out_valid = 0, stack_full = 0, res_rd = 0;
   logic [7:0] load_addr = 0;
   logic [31:0] load_data = 0;
   logic [10:0] psw = 0;
   logic [63:0] result_data = 0;
   logic core_rst, res_empty, res_ovf, busy, done;
   logic [31:0] instrn;
   logic [63:0] res_data;
   logic [3:0] res_count;
   logic [1:0] halt_cause;
   logic [15:0] instr_count;
   int errors = 0, checks = 0;
   risc_prog_server #(.RES_DEPTH(8), .MAX_INSTR(16'(MAXI))) dut (
      .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .start(start), .core_rst(core_rst), .instrn(instrn), .rd_instr(rd_instr), .psw(psw),
      .endofinstrn(endofinstrn), .result_data(result_data), .out_valid(out_valid),
      .stack_full(stack_full), .res_rd(res_rd), .res_data(res_data), .res_empty(res_empty),
      .res_count(res_count), .res_ovf(res_ovf), .busy(busy), .done(done),
      .halt_cause(halt_cause), .instr_count(instr_count));
   always #5 clk = ~clk;
   task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask
   // Reference model: 0=idle 1=run 2=done, FIFO as a bounded queue
   int m_state = 0;
   bit m_run, m_ovf;
   logic [31:0] m_instrn, m_mem [256];
   logic [63:0] q[$];
   logic [1:0] m_cause, m_c;
   logic [15:0] m_cnt;
   always @(posedge clk or posedge reset)
      if (reset) begin
         m_state = 0; m_instrn = 0; q.delete(); m_ovf = 0; m_cause = 0; m_cnt = 0;
      end else begin
         m_run = m_state == 1;
         m_c = (rd_instr && m_instrn == HALT) ? 2'd1 : stack_full ? 2'd2 :
               (endofinstrn && m_cnt == 16'(MAXI - 1)) ? 2'd3 : 2'd0;
         if (!m_run && load_we) m_mem[load_addr] = load_data;
         m_instrn = m_run ? m_mem[psw[10:3]] : 32'd0;
         if (res_rd && q.size() > 0) void'(q.pop_front());
         if (m_run && out_valid) begin
            if (q.size() < 8) q.push_back(result_data);
            else m_ovf = 1;
         end
         if (m_run && endofinstrn && m_cnt < 16'(MAXI)) m_cnt++;
         if (m_run && m_c != 0) begin m_state = 2; m_cause = m_c; end
         if (!m_run && start) begin m_state = 1; m_cnt = 0; m_cause = 0; m_ovf = 0; q.delete(); end
      end
   always @(negedge clk) begin
      check("core_rst", 64'(core_rst), 64'(m_state != 1));
      check("busy", 64'(busy), 64'(m_state == 1));
      check("done", 64'(done), 64'(m_state == 2));
      check("instrn", 64'(instrn), 64'(m_instrn));
      check("halt_cause", 64'(halt_cause), 64'(m_cause));
      check("instr_count", 64'(instr_count), 64'(m_cnt));
      check("res_count", 64'(res_count), 64'(q.size()));
      check("res_empty", 64'(res_empty), 64'(q.size() == 0));
      check("res_ovf", 64'(res_ovf), 64'(m_ovf));
      if (q.size() > 0) check("res_data", res_data, q[0]);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic load(input logic [7:0] a, input logic [31:0] d);
      load_we = 1; load_addr = a; load_data = d;
      tick();
      load_we = 0;
   endtask
   task automatic go();
      start = 1;
      tick();
      start = 0;
   endtask
   task automatic setpc(input logic [7:0] p);
      psw = {p, 3'b000};
   endtask
   initial begin
      tick(); tick();
      reset = 0;
      check("rst core_rst", 64'(core_rst), 1);
      check("rst instrn", 64'(instrn), 0);
      check("rst res_empty", 64'(res_empty), 1);
      check("rst done", 64'(done), 0);
      // program fetch ending on HALT_WORD
      load(0, WA); load(1, WB); load(2, HALT); load(3, WC);
      go();
      check("t1 busy", 64'(busy), 1);
      check("t1 core_rst", 64'(core_rst), 0);
      tick();
      check("t1 instrn A", 64'(instrn), 64'(WA));
      rd_instr = 1; setpc(1); tick();
      check("t1 instrn B", 64'(instrn), 64'(WB));
      setpc(2); tick();
      check("t1 instrn HALT", 64'(instrn), 64'(HALT));
      tick();
      check("t1 done", 64'(done), 1);
      check("t1 cause", 64'(halt_cause), 1);
      check("t1 core_rst", 64'(core_rst), 1);
      rd_instr = 0; setpc(0);
      // overflow then drain
      go();
      for (int i = 1; i <= 10; i++) begin
         out_valid = 1; result_data = 64'(i); tick();
      end
      out_valid = 0;
      check("t2 count", 64'(res_count), 8);
      check("t2 ovf", 64'(res_ovf), 1);
      for (int i = 1; i <= 8; i++) begin
         check("t2 pop data", res_data, 64'(i));
         res_rd = 1; tick(); res_rd = 0;
      end
      check("t2 empty", 64'(res_empty), 1);
      res_rd = 1; tick(); res_rd = 0;
      check("t2 empty pop", 64'(res_count), 0);
      stack_full = 1; tick(); stack_full = 0;
      check("t2 stack cause", 64'(halt_cause), 2);
      // simultaneous push and pop on a full FIFO
      go();
      check("t3 ovf cleared", 64'(res_ovf), 0);
      for (int i = 0; i < 8; i++) begin
         out_valid = 1; result_data = 64'(100 + i); tick();
      end
      out_valid = 1; res_rd = 1; result_data = 64'd999; tick();
      out_valid = 0; res_rd = 0;
      check("t3 count", 64'(res_count), 8);
      check("t3 ovf", 64'(res_ovf), 0);
      check("t3 head", res_data, 101);
      for (int i = 0; i < 7; i++) begin
         res_rd = 1; tick();
      end
      res_rd = 0;
      check("t3 tail", res_data, 999);
      // watchdog
      for (int i = 1; i <= 5; i++) begin
         endofinstrn = 1; tick();
         if (i == 4) check("t4 still busy", 64'(busy), 1);
      end
      check("t4 done", 64'(done), 1);
      check("t4 cause", 64'(halt_cause), 3);
      check("t4 count", 64'(instr_count), 5);
      tick();
      endofinstrn = 0;
      check("t4 hold", 64'(instr_count), 5);
      // HALT_WORD beats stack_full; writes ignored while running
      setpc(2); go();
      load_we = 1; load_addr = 3; load_data = 32'hDEAD_BEEF; tick(); load_we = 0;
      rd_instr = 1; stack_full = 1; tick();
      rd_instr = 0; stack_full = 0;
      check("t5 cause", 64'(halt_cause), 1);
      setpc(3); go(); tick();
      check("t5 mem kept", 64'(instrn), 64'(WC));
      // reset mid-run
      for (int i = 7; i <= 9; i++) begin
         out_valid = 1; result_data = 64'(i); tick();
      end
      out_valid = 0;
      check("t6 queued", 64'(res_count), 3);
      reset = 1; #1;
      check("t6 core_rst", 64'(core_rst), 1);
      check("t6 busy", 64'(busy), 0);
      check("t6 empty", 64'(res_empty), 1);
      check("t6 instrn", 64'(instrn), 0);
      tick(); reset = 0;
      setpc(0); go(); tick();
      check("t6 rerun A", 64'(instrn), 64'(WA));
      setpc(1); tick();
      check("t6 rerun B", 64'(instrn), 64'(WB));
      tick(); tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
